// File: rtl/jk_response_checker.sv
// Online checker for a JK flip-flop: aligns a reference model to the observed Q,
// then flags, counts and remembers divergences. Define JK_COMPLEMENT_CHECK_EN to also check Qnot.
module jk_response_checker #(
  parameter int COUNT_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               sample_valid,
  input  logic               J,
  input  logic               K,
  input  logic               Q,
  input  logic               Qnot,
  output logic               mismatch,
  output logic               fail,
  output logic               synced,
  output logic [COUNT_W-1:0] check_count,
  output logic [COUNT_W-1:0] error_count
);

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  function automatic logic jk_next(input logic q, input logic j, input logic k);
    case ({j, k})
      2'b00:   return q;
      2'b01:   return 1'b0;
      2'b10:   return 1'b1;
      default: return ~q;
    endcase
  endfunction

  state_t state, state_nx;
  logic   exp_q;
  logic   do_sync, do_check, bad;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    do_sync  = 1'b0;
    do_check = 1'b0;
    case (state)
      IDLE:  state_nx = SYNC;
      SYNC:  if (sample_valid) begin
               do_sync  = 1'b1;
               state_nx = CHECK;
             end
      CHECK: do_check = sample_valid;
      default: state_nx = IDLE;
    endcase
    // clear wins over any sample on the same edge
    if (clear) begin
      state_nx = SYNC;
      do_sync  = 1'b0;
      do_check = 1'b0;
    end
  end

`ifdef JK_COMPLEMENT_CHECK_EN
  assign bad = do_check && ((Q != exp_q) || (Qnot == Q));
`else
  assign bad = do_check && (Q != exp_q);
  logic unused_qnot;
  assign unused_qnot = Qnot;
`endif

  assign synced = (state == CHECK);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      exp_q       <= 1'b0;
      mismatch    <= 1'b0;
      fail        <= 1'b0;
      check_count <= '0;
      error_count <= '0;
    end else if (clear) begin
      mismatch    <= 1'b0;
      fail        <= 1'b0;
      check_count <= '0;
      error_count <= '0;
    end else begin
      mismatch <= bad;
      if (do_sync) exp_q <= jk_next(Q, J, K);
      if (do_check) begin
        // on a mismatch, re-align to the observed Q so one fault gives one error
        exp_q <= bad ? jk_next(Q, J, K) : jk_next(exp_q, J, K);
        if (check_count != CNT_MAX) check_count <= check_count + 1'b1;
      end
      if (bad) begin
        fail <= 1'b1;
        if (error_count != CNT_MAX) error_count <= error_count + 1'b1;
      end
    end
  end

endmodule
